// File: rtl/isqrt_rr_arbiter.sv
// isqrt_rr_arbiter: round-robin sharing of one pipelined isqrt among N_REQ clients,
// with an in-order tag FIFO that routes each result back to its issuer.
module isqrt_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MAX_OUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_vld,
    input  logic [32*N_REQ-1:0]   req_x,
    output logic [N_REQ-1:0]      req_rdy,
    output logic [N_REQ-1:0]      resp_vld,
    output logic [15:0]           resp_y,
    output logic                  isqrt_x_vld,
    output logic [31:0]           isqrt_x,
    input  logic                  isqrt_y_vld,
    input  logic [15:0]           isqrt_y,
    output logic                  busy,
    output logic                  err
);
    localparam int IW = $clog2(N_REQ);
    localparam int AW = $clog2(MAX_OUT);
    localparam logic [AW:0] FULL = (AW+1)'(MAX_OUT);
    logic [IW-1:0] ptr, win, cand;
    logic [IW:0]   sum;
    logic [AW:0]   count;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [IW-1:0] tags [MAX_OUT];
    logic          found, pop;
    // Scan from ptr with wrap; a full FIFO blocks issue even if a pop lands this cycle.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum  = {1'b0, ptr} + (IW+1)'(k);
            cand = IW'(sum >= (IW+1)'(N_REQ) ? sum - (IW+1)'(N_REQ) : sum);
            if (!found && req_vld[cand] && count != FULL) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end
    assign req_rdy     = found ? N_REQ'(1) << win : '0;
    assign isqrt_x_vld = found;
    assign isqrt_x     = found ? req_x[32*int'(win) +: 32] : '0;
    assign pop         = isqrt_y_vld && count != '0;
    assign busy        = count != '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            resp_vld <= '0;
            resp_y   <= '0;
            err      <= 1'b0;
        end else begin
            if (found) ptr <= (win == IW'(N_REQ-1)) ? '0 : win + 1'b1;
            if (found) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count    <= count + (AW+1)'(found) - (AW+1)'(pop);
            resp_vld <= pop ? N_REQ'(1) << tags[rd_ptr] : '0;
            resp_y   <= pop ? isqrt_y : resp_y;
            err      <= err | (isqrt_y_vld && count == '0);
        end
    end
    always_ff @(posedge clk) begin
        if (found) tags[wr_ptr] <= win;
    end
endmodule
